// File: rtl/picorv_mem_dma_if.sv
// picorv32 native memory bus as seen by the DMA initiator.
// master: the DMA engine, slave: the memory responder or arbiter port.
`timescale 1ns/1ps
interface picorv_mem_dma_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv_mem_dma.sv
// Word-copy DMA engine, initiator on the picorv32 native memory bus.
// Alternates one read and one write per word, buffering the word in mem_wdata.
// Optional fill mode is enabled by defining PICORV_DMA_FILL_EN: a command with
// cmd_fill=1 then skips reads and writes cmd_pattern to every destination word.
`timescale 1ns/1ps
module picorv_mem_dma #(
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_src,
    input  logic [31:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_fill,
    input  logic [31:0]      cmd_pattern,
    output logic             busy,
    output logic             done,
    output logic             error,
    picorv_mem_dma_if.master mem
);

`ifdef PICORV_DMA_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t           state, state_nx;
    logic [31:0]      src, src_nx;
    logic [31:0]      dst, dst_nx;
    logic [LEN_W-1:0] len, len_nx;
    logic             fill, fill_nx;
    logic [15:0]      wait_cnt, wait_nx;
    logic             valid_nx;
    logic [31:0]      addr_nx;
    logic [31:0]      wdata_nx;
    logic [3:0]       wstrb_nx;
    logic             busy_nx, done_nx, error_nx;
    logic             expired;

    assign cmd_ready     = (state == IDLE);
    assign mem.mem_instr = 1'b0;
    assign expired       = (wait_cnt == WAIT_LAST);

    // Next-state and next-output decode; outputs are registered below.
    // mem_wdata doubles as the one-word buffer (read data or fill pattern).
    always_comb begin
        state_nx = state;
        src_nx   = src;
        dst_nx   = dst;
        len_nx   = len;
        fill_nx  = fill;
        wait_nx  = wait_cnt;
        valid_nx = mem.mem_valid;
        addr_nx  = mem.mem_addr;
        wdata_nx = mem.mem_wdata;
        wstrb_nx = mem.mem_wstrb;
        busy_nx  = busy;
        done_nx  = 1'b0;
        error_nx = error;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    error_nx = 1'b0;
                    if (cmd_len == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        src_nx   = {cmd_src[31:2], 2'b00};
                        dst_nx   = {cmd_dst[31:2], 2'b00};
                        len_nx   = cmd_len;
                        fill_nx  = FILL_ON & cmd_fill;
                        wait_nx  = '0;
                        valid_nx = 1'b1;
                        busy_nx  = 1'b1;
                        if (FILL_ON && cmd_fill) begin
                            state_nx = WR;
                            addr_nx  = {cmd_dst[31:2], 2'b00};
                            wdata_nx = cmd_pattern;
                            wstrb_nx = '1;
                        end else begin
                            state_nx = RD;
                            addr_nx  = {cmd_src[31:2], 2'b00};
                            wstrb_nx = '0;
                        end
                    end
                end
            end
            RD: begin
                if (mem.mem_ready) begin
                    src_nx   = src + 32'd4;
                    wdata_nx = mem.mem_rdata;
                    addr_nx  = dst;
                    wstrb_nx = '1;
                    wait_nx  = '0;
                    state_nx = WR;
                end else if (expired) begin
                    valid_nx = 1'b0;
                    wstrb_nx = '0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    error_nx = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wait_nx = wait_cnt + 16'd1;
                end
            end
            WR: begin
                if (mem.mem_ready) begin
                    dst_nx  = dst + 32'd4;
                    len_nx  = len - LEN_W'(1);
                    wait_nx = '0;
                    if (len == LEN_W'(1)) begin
                        valid_nx = 1'b0;
                        wstrb_nx = '0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else if (fill) begin
                        addr_nx = dst + 32'd4;
                    end else begin
                        addr_nx  = src;
                        wstrb_nx = '0;
                        state_nx = RD;
                    end
                end else if (expired) begin
                    valid_nx = 1'b0;
                    wstrb_nx = '0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    error_nx = 1'b1;
                    state_nx = IDLE;
                end else begin
                    wait_nx = wait_cnt + 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and registered outputs; synchronous active-low reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            len           <= '0;
            fill          <= 1'b0;
            wait_cnt      <= '0;
            mem.mem_valid <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_nx;
            src           <= src_nx;
            dst           <= dst_nx;
            len           <= len_nx;
            fill          <= fill_nx;
            wait_cnt      <= wait_nx;
            mem.mem_valid <= valid_nx;
            mem.mem_addr  <= addr_nx;
            mem.mem_wdata <= wdata_nx;
            mem.mem_wstrb <= wstrb_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            error         <= error_nx;
        end
    end

endmodule

// File: tb/tb_picorv_mem_dma.sv
// Bench for picorv_mem_dma: memory responder with programmable wait states,
// word-level reference model of copy/fill results and cycle timing.
`timescale 1ns/1ps
module tb_picorv_mem_dma;
    localparam int unsigned LEN_W    = 16;
    localparam int unsigned MAX_WAIT = 8;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [31:0]      cmd_src = '0;
    logic [31:0]      cmd_dst = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_fill = 1'b0;
    logic [31:0]      cmd_pattern = '0;
    logic             busy, done, error;

    picorv_mem_dma_if bus ();

    picorv_mem_dma #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .cmd_fill(cmd_fill), .cmd_pattern(cmd_pattern),
        .busy(busy), .done(done), .error(error),
        .mem(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] ram [logic [31:0]];
    int unsigned wcnt = 0, cur_wait = 0, resp_wait = 0;
    bit          rand_wait = 1'b0, no_ready = 1'b0;
    int          nrd = 0, nwr = 0;
    int unsigned wait_log[$];
    logic [31:0] wr_log[$];

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : (32'hA5A5_0000 ^ a);
    endfunction

    function automatic int unsigned next_wait();
        return rand_wait ? $urandom_range(0, 4) : resp_wait;
    endfunction

    always @(posedge clk) begin
        if (!resetn || !bus.mem_valid) begin
            bus.mem_ready <= 1'b0;
            wcnt <= 0;
            cur_wait = next_wait();
        end else if (bus.mem_ready) begin
            if (bus.mem_wstrb == 4'hF) begin
                ram[bus.mem_addr] = bus.mem_wdata;
                nwr++;
                wr_log.push_back(bus.mem_addr);
            end else begin
                nrd++;
            end
            bus.mem_ready <= 1'b0;
            wcnt <= 0;
            cur_wait = next_wait();
        end else if (!no_ready && wcnt >= cur_wait) begin
            bus.mem_ready <= 1'b1;
            bus.mem_rdata <= ram_rd(bus.mem_addr);
            wait_log.push_back(wcnt);
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    // Request must hold still while waiting for mem_ready.
    bit          chk_stable = 1'b0;
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pa, pd;
    logic [3:0]  ps;
    always @(negedge clk) begin
        if (chk_stable && pv && !pr && bus.mem_valid) begin
            check("stable_addr", bus.mem_addr, pa);
            check("stable_wdata", bus.mem_wdata, pd);
            check("stable_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, ps});
        end
        pv = bus.mem_valid;
        pr = bus.mem_ready;
        pa = bus.mem_addr;
        pd = bus.mem_wdata;
        ps = bus.mem_wstrb;
    end

    task automatic clear_stats();
        nrd = 0;
        nwr = 0;
        wait_log.delete();
        wr_log.delete();
    endtask

    // Issue one command; done_cyc = cycle (1 = cycle after accept edge) in which done is seen.
    task automatic run_cmd(input string tag, input logic [31:0] src, input logic [31:0] dst,
                           input int len, input logic fill, input logic [31:0] pat,
                           input bit poke, output int done_cyc, output int vcyc);
        @(negedge clk);
        clear_stats();
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_src = src;
        cmd_dst = dst;
        cmd_len = LEN_W'(len);
        cmd_fill = fill;
        cmd_pattern = pat;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        done_cyc = -1;
        vcyc = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (poke && c == 3) begin
                cmd_valid = 1'b1;
                cmd_src = 32'h7700_0000;
                cmd_dst = 32'h7800_0000;
                cmd_len = LEN_W'(5);
            end
            if (poke && c == 7) cmd_valid = 1'b0;
            if (bus.mem_valid) vcyc++;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (done_cyc > 0) begin
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            check({tag, "_ready_at_done"}, {31'd0, cmd_ready}, 32'd1);
            @(negedge clk);
            check({tag, "_done_width"}, {31'd0, done}, 32'd0);
        end
    endtask

    int          dc, vc, exp_dc, len, found, bad;
    logic [31:0] s, d, v;
    logic [31:0] exp_words[$];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("instr", {31'd0, bus.mem_instr}, 32'd0);
        resetn = 1'b1;

        // 4-word copy, zero wait
        for (int i = 0; i < 4; i++) ram[32'h4000_0100 + 4 * i] = 32'h1111_1111 * (i + 1);
        resp_wait = 0;
        run_cmd("copy4", 32'h4000_0100, 32'h4000_0200, 4, 1'b0, 32'd0, 1'b0, dc, vc);
        check("copy4_done_cyc", dc, 17);
        check("copy4_error", {31'd0, error}, 32'd0);
        check("copy4_txns", nrd + nwr, 8);
        for (int i = 0; i < 4; i++)
            check("copy4_data", ram_rd(32'h4000_0200 + 4 * i), 32'h1111_1111 * (i + 1));

        // zero-length command
        run_cmd("len0", 32'h4000_0100, 32'h4000_0200, 0, 1'b0, 32'd0, 1'b0, dc, vc);
        check("len0_done_cyc", dc, 1);
        check("len0_valid_cycles", vc, 0);
        check("len0_txns", nrd + nwr, 0);

        // 3 wait states per transaction, request stability monitored
        ram[32'h5000_0000] = 32'hCAFE_0001;
        ram[32'h5000_0004] = 32'hCAFE_0002;
        resp_wait = 3;
        chk_stable = 1'b1;
        run_cmd("wait3", 32'h5000_0000, 32'h5000_1000, 2, 1'b0, 32'd0, 1'b0, dc, vc);
        chk_stable = 1'b0;
        check("wait3_done_cyc", dc, 1 + 2 * 2 * (3 + 2));
        check("wait3_w0", ram_rd(32'h5000_1000), 32'hCAFE_0001);
        check("wait3_w1", ram_rd(32'h5000_1004), 32'hCAFE_0002);

        // responder never ready -> timeout after MAX_WAIT cycles
        no_ready = 1'b1;
        run_cmd("tmo", 32'h5000_0000, 32'h5000_2000, 2, 1'b0, 32'd0, 1'b0, dc, vc);
        no_ready = 1'b0;
        check("tmo_done_cyc", dc, MAX_WAIT + 1);
        check("tmo_valid_cycles", vc, MAX_WAIT);
        check("tmo_error", {31'd0, error}, 32'd1);
        check("tmo_txns", nrd + nwr, 0);
        repeat (3) @(negedge clk);
        check("tmo_error_holds", {31'd0, error}, 32'd1);
        resp_wait = 0;
        run_cmd("clr", 32'h5000_0000, 32'h5000_2000, 0, 1'b0, 32'd0, 1'b0, dc, vc);
        check("clr_error", {31'd0, error}, 32'd0);

        // ready on the expiry edge still succeeds; one cycle later times out
        ram[32'h5100_0000] = 32'h0BAD_F00D;
        resp_wait = MAX_WAIT - 2;
        run_cmd("tie", 32'h5100_0000, 32'h5100_1000, 1, 1'b0, 32'd0, 1'b0, dc, vc);
        check("tie_done_cyc", dc, 1 + 2 * MAX_WAIT);
        check("tie_error", {31'd0, error}, 32'd0);
        check("tie_data", ram_rd(32'h5100_1000), 32'h0BAD_F00D);
        resp_wait = MAX_WAIT - 1;
        run_cmd("late", 32'h5100_0000, 32'h5100_2000, 1, 1'b0, 32'd0, 1'b0, dc, vc);
        check("late_done_cyc", dc, MAX_WAIT + 1);
        check("late_error", {31'd0, error}, 32'd1);
        check("late_txns", nrd + nwr, 0);

        // reset during the write of word 2 of 5 (error is still set from above)
        for (int i = 0; i < 5; i++) begin
            ram[32'h4800_0000 + 4 * i] = 32'h4800_AA00 + i;
            ram[32'h4900_0000 + 4 * i] = 32'h5E5E_0000 + i;
        end
        resp_wait = 3;
        @(negedge clk);
        clear_stats();
        cmd_valid = 1'b1;
        cmd_src = 32'h4800_0000;
        cmd_dst = 32'h4900_0000;
        cmd_len = LEN_W'(5);
        cmd_fill = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.mem_valid && bus.mem_wstrb == 4'hF && nwr == 1) begin
                found = 1;
                break;
            end
        end
        check("rst_mid_found", found, 1);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("rst_mid_addr", bus.mem_addr, 32'd0);
        check("rst_mid_wdata", bus.mem_wdata, 32'd0);
        check("rst_mid_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_error", {31'd0, error}, 32'd0);
        check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        resetn = 1'b1;
        bad = 0;
        vc = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) bad++;
            if (bus.mem_valid) vc++;
        end
        check("rst_mid_no_done", bad, 0);
        check("rst_mid_quiet", vc, 0);
        check("rst_mid_w1", ram_rd(32'h4900_0000), 32'h4800_AA00);
        for (int i = 1; i < 5; i++)
            check("rst_mid_unwritten", ram_rd(32'h4900_0000 + 4 * i), 32'h5E5E_0000 + i);

        // destination wraps past the top of the address space
        for (int i = 0; i < 3; i++) ram[32'h7000_0000 + 4 * i] = 32'h7000_0A00 + i;
        resp_wait = 0;
        run_cmd("wrap", 32'h7000_0000, 32'hFFFF_FFF8, 3, 1'b0, 32'd0, 1'b0, dc, vc);
        check("wrap_done_cyc", dc, 13);
        check("wrap_nwr", nwr, 3);
        if (wr_log.size() == 3) begin
            check("wrap_a0", wr_log[0], 32'hFFFF_FFF8);
            check("wrap_a1", wr_log[1], 32'hFFFF_FFFC);
            check("wrap_a2", wr_log[2], 32'h0000_0000);
        end
        check("wrap_d2", ram_rd(32'h0000_0000), 32'h7000_0A02);

        // commands offered while busy are dropped
        run_cmd("poke", 32'h7000_0000, 32'h7100_0000, 3, 1'b0, 32'd0, 1'b1, dc, vc);
        check("poke_done_cyc", dc, 13);
        check("poke_nrd", nrd, 3);
        check("poke_nwr", nwr, 3);
        check("poke_no_dst", {31'd0, ram.exists(32'h7800_0000)}, 32'd0);
        repeat (4) @(negedge clk);
        check("poke_idle", {31'd0, busy}, 32'd0);

        // randomized copies with random per-transaction wait states
        rand_wait = 1'b1;
        for (int it = 0; it < 10; it++) begin
            s = 32'h1000_0000 | ($urandom_range(0, 1023) << 2);
            d = 32'h2000_0000 | ($urandom_range(0, 1023) << 2);
            len = $urandom_range(1, 6);
            exp_words.delete();
            for (int i = 0; i < len; i++) begin
                v = $urandom;
                ram[s + 4 * i] = v;
                exp_words.push_back(v);
            end
            run_cmd("rnd", s | $urandom_range(0, 3), d | $urandom_range(0, 3), len,
                    1'b0, 32'd0, 1'b0, dc, vc);
            exp_dc = 1;
            foreach (wait_log[k]) exp_dc += wait_log[k] + 2;
            check("rnd_txns", wait_log.size(), 2 * len);
            check("rnd_done_cyc", dc, exp_dc);
            check("rnd_error", {31'd0, error}, 32'd0);
            check("rnd_nwr", nwr, len);
            for (int i = 0; i < len; i++) begin
                check("rnd_data", ram_rd(d + 4 * i), exp_words[i]);
                if (i < wr_log.size()) check("rnd_waddr", wr_log[i], d + 4 * i);
            end
        end
        rand_wait = 1'b0;

        // fill command: only writes when fill is built in, otherwise a plain copy
        for (int i = 0; i < 3; i++) ram[32'h4A00_0000 + 4 * i] = 32'h4A00_0C00 + i;
        resp_wait = 0;
        run_cmd("fill", 32'h4A00_0000, 32'h4000_0300, 3, 1'b1, 32'hDEAD_BEEF, 1'b0, dc, vc);
`ifdef PICORV_DMA_FILL_EN
        check("fill_done_cyc", dc, 7);
        check("fill_nrd", nrd, 0);
        check("fill_nwr", nwr, 3);
        for (int i = 0; i < 3; i++)
            check("fill_data", ram_rd(32'h4000_0300 + 4 * i), 32'hDEAD_BEEF);
`else
        check("fill_done_cyc", dc, 13);
        check("fill_nrd", nrd, 3);
        check("fill_nwr", nwr, 3);
        for (int i = 0; i < 3; i++)
            check("fill_data", ram_rd(32'h4000_0300 + 4 * i), 32'h4A00_0C00 + i);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/picorv_mem_dma.md
# picorv_mem_dma

Word-copy DMA engine that acts as an initiator on the picorv32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata). It accepts a command (source, destination, word count) and issues alternating read and write transactions, buffering one word. It sits beside the core as a second bus master behind the native-bus arbiter, and standalone against the bench memory responder.

## Interface
- LEN_W, 16: width of word-count field; max transfer 2^LEN_W-1 words.
- MAX_WAIT, 255: cycles a transaction may wait for mem_ready before timeout (1..2^16-1).

- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready at an edge.
- cmd_src  in  32  source byte address; bits [1:0] ignored (forced 00).
- cmd_dst  in  32  destination byte address; bits [1:0] ignored.
- cmd_len  in  LEN_W  number of 32-bit words.
- cmd_fill  in  1  fill mode select (see Configuration).
- cmd_pattern  in  32  fill word.
- busy  out  1  high in RD/WR states.
- done  out  1  one-cycle pulse on completion or timeout.
- error  out  1  sticky timeout flag; cleared on next command accept.
- mem_valid  out  1  transaction request.
- mem_instr  out  1  constant 0.
- mem_ready  in  1  responder completion.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b1111 on writes, 4'b0000 on reads.
- mem_rdata  in  32  read data, valid when mem_ready=1.

## Operation
- States: IDLE, RD, WR. All outputs registered except cmd_ready (= state==IDLE).
- Reset (resetn=0 at edge): state IDLE; mem_valid, mem_addr, mem_wdata, mem_wstrb, busy, done, error all 0; counters cleared. Reset mid-transfer aborts at that edge, no done pulse, remaining words not written.
- IDLE + accept, cmd_len=0: no bus traffic; done=1 next cycle, state stays IDLE.
- IDLE + accept, cmd_len>0: latch src, dst, len, pattern; error<=0; go RD (or WR if fill active).
- RD: mem_valid=1, mem_addr=src, mem_wstrb=0. At edge with mem_ready=1: capture mem_rdata into buffer, src<=src+4, go WR.
- WR: mem_valid=1, mem_addr=dst, mem_wdata=buffer, mem_wstrb=4'b1111. At edge with mem_ready=1: dst<=dst+4, len<=len-1; if len==1 go IDLE with done=1, mem_valid=0, else go RD.
- mem_addr/mem_wdata/mem_wstrb stable while mem_valid=1 and mem_ready=0. mem_valid stays high across RD->WR and WR->RD transitions; address/strobe change on the edge that samples mem_ready.
- Address increment wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
- Timeout: wait counter resets on each new transaction; when MAX_WAIT cycles elapse with mem_ready=0, mem_valid<=0, error<=1, done<=1, go IDLE. mem_ready arriving in the same edge as expiry counts as success.
- cmd_valid while busy is ignored (not queued).

## Timing
- Accept at edge E0 -> mem_valid=1 from cycle after E0.
- With a responder asserting mem_ready one cycle after mem_valid: read 2 cycles, write 2 cycles, 4 cycles/word copy, 2 cycles/word fill.
- N-word copy: done pulses 4N+1 cycles after accept edge; busy low and cmd_ready high in that same cycle.
- done width exactly one cycle; error holds until next accept.

## Configuration
- PICORV_DMA_FILL_EN defined: cmd_fill=1 at accept skips RD entirely; every WR writes cmd_pattern to successive dst words.
- Undefined: cmd_fill and cmd_pattern ports exist but are ignored; every command is a copy.

## Test plan
- Copy 4 words src 0x4000_0100 (0x11111111,0x22222222,0x33333333,0x44444444) to dst 0x4000_0200 -> destination matches, done 17 cycles after accept, error=0, exactly 8 transactions.
- cmd_len=0 -> no mem_valid assertion, done one cycle after accept.
- Responder with 3 wait cycles; mem_addr/wdata/wstrb checked stable during wait -> copy of 2 words correct, done at 4*2*... per-word 10 cycles observed.
- Responder never asserts ready, MAX_WAIT=8 -> mem_valid drops after 8 cycles, done=1 and error=1; next command clears error.
- resetn low during WR of word 2 of 5 -> next edge all outputs 0, state IDLE, words 3-5 unwritten, no done.
- With PICORV_DMA_FILL_EN, fill 3 words 0xDEADBEEF at 0x4000_0300 -> only writes, done 7 cycles after accept; without macro same command performs copy.
